// File: rtl/mini_alu_arbiter.sv
// rtl/mini_alu_arbiter.sv - two-requester round-robin front end for an external mini_alu
// Optional condition-code register: define MINI_ALU_ARBITER_ICC_EN.
module mini_alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_cin,
`ifdef MINI_ALU_ARBITER_ICC_EN
  input  logic        req0_setcc,
`endif
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_cin,
`ifdef MINI_ALU_ARBITER_ICC_EN
  input  logic        req1_setcc,
`endif
  output logic        resp0_valid,
  output logic        resp1_valid,
  output logic [31:0] resp_y,
  output logic [3:0]  resp_flags,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_cin,
  output logic [3:0]  alu_opcode,
  input  logic [31:0] alu_y,
  input  logic [3:0]  alu_flags,
`ifdef MINI_ALU_ARBITER_ICC_EN
  output logic [3:0]  icc,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      r_state;
  logic        r_last;
  logic        r_owner;
  logic [1:0]  r_resp_valid;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic        r_alu_cin;
  logic [3:0]  r_alu_op;
  logic [31:0] r_resp_y;
  logic [3:0]  r_resp_flags;
`ifdef MINI_ALU_ARBITER_ICC_EN
  logic        r_setcc;
  logic [3:0]  r_icc;
`endif

  logic w_idle;
  logic w_grant0;
  logic w_grant1;

  // r_last=1 means requester 1 won last, so requester 0 wins the next tie.
  assign w_idle   = rst_n && (r_state == IDLE);
  assign w_grant1 = req1_valid && (!req0_valid || !r_last);
  assign w_grant0 = req0_valid && !w_grant1;

  assign req0_ready  = w_idle && w_grant0;
  assign req1_ready  = w_idle && w_grant1;
  assign busy        = (r_state != IDLE);
  assign resp0_valid = r_resp_valid[0];
  assign resp1_valid = r_resp_valid[1];
  assign resp_y      = r_resp_y;
  assign resp_flags  = r_resp_flags;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_cin     = r_alu_cin;
  assign alu_opcode  = r_alu_op;
`ifdef MINI_ALU_ARBITER_ICC_EN
  assign icc         = r_icc;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last       <= 1'b1;
      r_owner      <= 1'b0;
      r_resp_valid <= 2'b00;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_cin    <= 1'b0;
      r_alu_op     <= '0;
      r_resp_y     <= '0;
      r_resp_flags <= '0;
`ifdef MINI_ALU_ARBITER_ICC_EN
      r_setcc      <= 1'b0;
      r_icc        <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_resp_valid <= 2'b00;
          if (w_grant0 || w_grant1) begin
            r_owner   <= w_grant1;
            r_last    <= w_grant1;
            r_alu_a   <= w_grant1 ? req1_a   : req0_a;
            r_alu_b   <= w_grant1 ? req1_b   : req0_b;
            r_alu_cin <= w_grant1 ? req1_cin : req0_cin;
            r_alu_op  <= w_grant1 ? req1_op  : req0_op;
`ifdef MINI_ALU_ARBITER_ICC_EN
            r_setcc   <= w_grant1 ? req1_setcc : req0_setcc;
`endif
            r_state   <= EXEC;
          end
        end
        EXEC: begin
          r_resp_y     <= alu_y;
          r_resp_flags <= alu_flags;
`ifdef MINI_ALU_ARBITER_ICC_EN
          if (r_setcc) r_icc <= alu_flags;
`endif
          r_resp_valid <= r_owner ? 2'b10 : 2'b01;
          r_state      <= RESP;
        end
        RESP: begin
          r_resp_valid <= 2'b00;
          r_state      <= IDLE;
        end
        default: begin
          r_resp_valid <= 2'b00;
          r_state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mini_alu_arbiter.sv
// tb/tb_mini_alu_arbiter.sv - directed self-checking bench for mini_alu_arbiter
// A small behavioural ALU stub answers the alu_* outputs.
module tb_mini_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_cin, req1_cin;
  logic        resp0_valid, resp1_valid;
  logic [31:0] resp_y;
  logic [3:0]  resp_flags;
  logic [31:0] alu_a, alu_b, alu_y;
  logic        alu_cin;
  logic [3:0]  alu_opcode, alu_flags;
  logic        busy;
`ifdef MINI_ALU_ARBITER_ICC_EN
  logic        req0_setcc, req1_setcc;
  logic [3:0]  icc;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  mini_alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
`ifdef MINI_ALU_ARBITER_ICC_EN
    .req0_setcc(req0_setcc),
`endif
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
`ifdef MINI_ALU_ARBITER_ICC_EN
    .req1_setcc(req1_setcc),
`endif
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp_y(resp_y), .resp_flags(resp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_opcode(alu_opcode),
    .alu_y(alu_y), .alu_flags(alu_flags),
`ifdef MINI_ALU_ARBITER_ICC_EN
    .icc(icc),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub ALU: 0 add, 1 sub, 2 and, 3 or, else xor; flags = {N, Z, C, V=0}
  logic [32:0] w_sum;
  logic        w_c;
  always_comb begin
    w_sum = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_cin};
    w_c   = 1'b0;
    case (alu_opcode)
      4'd0: begin alu_y = w_sum[31:0]; w_c = w_sum[32]; end
      4'd1: alu_y = alu_a - alu_b;
      4'd2: alu_y = alu_a & alu_b;
      4'd3: alu_y = alu_a | alu_b;
      default: alu_y = alu_a ^ alu_b;
    endcase
    alu_flags = {alu_y[31], (alu_y == 32'd0), w_c, 1'b0};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [11:0] acc_mask, rsp_mask;
  logic [3:0]  grants;
  int          n_grant;
  logic        saw_resp;

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd0; req0_b = 32'd0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_op = 4'd0; req1_a = 32'd0; req1_b = 32'd0; req1_cin = 1'b0;
`ifdef MINI_ALU_ARBITER_ICC_EN
    req0_setcc = 1'b0; req1_setcc = 1'b0;
`endif

    // reset state, with a valid request present
    @(negedge clk);
    chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_resp0", {31'd0, resp0_valid}, 32'd0);
    chk("rst_resp_y", resp_y, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_op", {28'd0, alu_opcode}, 32'd0);
`ifdef MINI_ALU_ARBITER_ICC_EN
    chk("rst_icc", {28'd0, icc}, 32'd0);
`endif
    tick(); req0_valid = 1'b0; rst_n = 1'b1;
    tick();

    // single request: 1 + 2
    req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd1; req0_b = 32'd2;
    @(negedge clk);
    chk("t1_ready0", {31'd0, req0_ready}, 32'd1);
    chk("t1_ready1", {31'd0, req1_ready}, 32'd0);
    chk("t1_busy_idle", {31'd0, busy}, 32'd0);
    tick(); req0_valid = 1'b0;
    @(negedge clk);
    chk("t1_busy_exec", {31'd0, busy}, 32'd1);
    chk("t1_alu_a", alu_a, 32'd1);
    chk("t1_resp0_early", {31'd0, resp0_valid}, 32'd0);
    tick();
    @(negedge clk);
    chk("t1_resp0", {31'd0, resp0_valid}, 32'd1);
    chk("t1_resp1", {31'd0, resp1_valid}, 32'd0);
    chk("t1_y", resp_y, 32'd3);
    chk("t1_flags", {28'd0, resp_flags}, 32'd0);
    tick();
    @(negedge clk);
    chk("t1_resp0_off", {31'd0, resp0_valid}, 32'd0);
    chk("t1_busy_done", {31'd0, busy}, 32'd0);
    chk("t1_y_hold", resp_y, 32'd3);

    // zero result, setcc=1
    req0_valid = 1'b1; req0_a = 32'd0; req0_b = 32'd0;
`ifdef MINI_ALU_ARBITER_ICC_EN
    req0_setcc = 1'b1;
`endif
    tick(); req0_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("z_resp0", {31'd0, resp0_valid}, 32'd1);
    chk("z_flags", {28'd0, resp_flags}, 32'h4);
`ifdef MINI_ALU_ARBITER_ICC_EN
    chk("z_icc", {28'd0, icc}, 32'h4);
`endif
    tick();
    // carry-out wrap, setcc=0
    req0_valid = 1'b1; req0_a = 32'hFFFF_FFFF; req0_b = 32'd1;
`ifdef MINI_ALU_ARBITER_ICC_EN
    req0_setcc = 1'b0;
`endif
    @(negedge clk);
    chk("c_ready0", {31'd0, req0_ready}, 32'd1);
    tick(); req0_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("c_y", resp_y, 32'd0);
    chk("c_flags", {28'd0, resp_flags}, 32'h6);
`ifdef MINI_ALU_ARBITER_ICC_EN
    chk("c_icc_hold", {28'd0, icc}, 32'h4);
`endif

    // tie right after reset: req0 first, req1 at T+3, resp1 at T+5
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    tick();
    req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd5; req0_b = 32'd6;
    req1_valid = 1'b1; req1_op = 4'd2; req1_a = 32'h0000_F0F0; req1_b = 32'h0000_FF00;
    @(negedge clk);
    chk("tie_ready0", {31'd0, req0_ready}, 32'd1);
    chk("tie_ready1", {31'd0, req1_ready}, 32'd0);
    tick(); req0_valid = 1'b0;
    @(negedge clk);
    chk("tie_ready1_exec", {31'd0, req1_ready}, 32'd0);
    tick();
    @(negedge clk);
    chk("tie_resp0", {31'd0, resp0_valid}, 32'd1);
    chk("tie_ready1_resp", {31'd0, req1_ready}, 32'd0);
    chk("tie_y0", resp_y, 32'd11);
    tick();
    @(negedge clk);
    chk("tie_ready1_t3", {31'd0, req1_ready}, 32'd1);
    tick(); req1_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("tie_resp1", {31'd0, resp1_valid}, 32'd1);
    chk("tie_resp0_off", {31'd0, resp0_valid}, 32'd0);
    chk("tie_y1", resp_y, 32'h0000_F000);
    tick();

    // sustained contention for 12 cycles
    req0_valid = 1'b1; req0_op = 4'd1; req0_a = 32'd10; req0_b = 32'd3;
    req1_valid = 1'b1; req1_op = 4'd3; req1_a = 32'h0F; req1_b = 32'hF0;
    acc_mask = '0; rsp_mask = '0; grants = '0; n_grant = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      acc_mask[i] = req0_ready | req1_ready;
      rsp_mask[i] = resp0_valid | resp1_valid;
      if ((req0_ready | req1_ready) && n_grant < 4) begin
        grants[n_grant] = req1_ready;
        n_grant++;
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rr_accept_mask", {20'd0, acc_mask}, 32'h249);
    chk("rr_resp_mask", {20'd0, rsp_mask}, 32'h924);
    chk("rr_grant_order", {28'd0, grants}, 32'hA);
    chk("rr_last_y", resp_y, 32'hFF);
    tick(); tick();

    // operand change after acceptance must not leak into the result
    req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd100; req0_b = 32'd1;
    @(negedge clk);
    chk("stab_ready0", {31'd0, req0_ready}, 32'd1);
    tick(); req0_valid = 1'b0; req0_a = 32'd999;
    tick();
    @(negedge clk);
    chk("stab_y", resp_y, 32'd101);
    chk("stab_alu_a_hold", alu_a, 32'd100);
    tick();

    // reset during EXEC aborts, then a fresh request completes
    req1_valid = 1'b1; req1_op = 4'd4; req1_a = 32'hFF; req1_b = 32'h0F;
    @(negedge clk);
    chk("abort_ready1", {31'd0, req1_ready}, 32'd1);
    tick(); req1_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_y", resp_y, 32'd0);
    tick(); rst_n = 1'b1;
    saw_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      saw_resp = saw_resp | resp0_valid | resp1_valid;
      tick();
    end
    chk("abort_no_resp", {31'd0, saw_resp}, 32'd0);
    req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd7; req0_b = 32'd8;
    @(negedge clk);
    chk("fresh_ready0", {31'd0, req0_ready}, 32'd1);
    tick(); req0_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("fresh_resp0", {31'd0, resp0_valid}, 32'd1);
    chk("fresh_y", resp_y, 32'd15);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
